multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle control unit for the RISC-V core; it sits on the initiator side of the ALU interface.
- Holds the instruction register (IR) and sequences FETCH/DECODE/EXEC/MEM/WB.
- Drives ALU opcode, operand selects, memory request, register-file write and PC update; consumes the ALU comparison flag.
- Opcode values are the macros in miriscv_defines.v.

Parameters:
- ALU_OP_W, `ALU_OP_WIDTH (5), width of alu_op_o.
- RESET_IR, 32'h00000013, IR value after reset (ADDI x0,x0,0).

Ports:
- clk_i  in  1  clock, rising edge.
- arstn_i  in  1  reset: asynchronous assert, active-low.
- mem_rdata_i  in  32  instruction/data read bus.
- mem_ready_i  in  1  memory completes the current request this cycle.
- alu_flag_i  in  1  ALU Flag output.
- instr_o  out  32  current IR contents, fed to regfile/immediate generator.
- alu_op_o  out  ALU_OP_W  ALU operation.
- src_a_sel_o  out  2  operand A select: 0 rs1, 1 PC, 2 zero.
- src_b_sel_o  out  3  operand B select: 0 rs2, 1 imm_I, 2 imm_S, 3 imm_U, 4 const 4.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  store when mem_req_o=1.
- mem_addr_sel_o  out  1  memory address: 0 PC, 1 ALU result.
- rf_we_o  out  1  register-file write enable.
- wb_sel_o  out  2  write-back source: 0 ALU, 1 mem_rdata_i, 2 PC+4.
- pc_we_o  out  1  PC register load.
- pc_sel_o  out  2  next PC: 0 PC+4, 1 PC+imm_B, 2 PC+imm_J, 3 ALU result with bit0 cleared.
- illegal_o  out  1  illegal instruction, sticky.

Behaviour:
- Reset (arstn_i=0, asynchronous):
  - state = FETCH; IR = RESET_IR.
  - All enables (mem_req_o, mem_we_o, rf_we_o, pc_we_o, illegal_o) = 0.
  - Selects = 0; alu_op_o = ALU_ADD (5'b00000).
  - Reset mid-request drops mem_req_o in the same cycle; no partial write reaches rf/PC.
- Outputs are Moore decodes of state + IR. Only IR and state are registered.
- FETCH:
  - mem_req_o=1, mem_addr_sel_o=0.
  - Hold until mem_ready_i=1, then load IR from mem_rdata_i and go to DECODE.
- DECODE:
  - One cycle, no enables.
  - Illegal IR goes to TRAP; otherwise go to EXEC.
- EXEC by opcode:
  - OP (0110011): map funct3/funct7 to ADD 00000, SUB 01000, SLL 00001, SLTS 00010, SLTU 00011, XOR 00100, SRL 00101, SRA 01101, OR 00110, AND 00111. Any funct7 other than 0x00 (and 0x20 for ADD/SRL only) is illegal. Selects A=0, B=0. Next: WB.
  - OP-IMM (0010011): same map, B=1. funct7 is checked only for shifts: SLLI/SRLI need 0x00, SRAI needs 0x20. Next: WB.
  - LOAD (0000011) / STORE (0100011): alu_op=ADD, A=0, B=1 (load) or 2 (store). Next: MEM.
  - BRANCH (1100011): funct3 000 EQ 11000, 001 NE 11001, 100 LTS 11100, 101 GES 11101, 110 LTU 11110, 111 GEU 11111; 010/011 are illegal. pc_we_o=1 with pc_sel_o = alu_flag_i ? 1 : 0. Next: FETCH.
  - LUI (0110111): ADD, A=2, B=3. Next: WB.
  - AUIPC (0010111): ADD, A=1, B=3. Next: WB.
  - JAL (1101111): Next: WB, wb_sel=2, pc_sel=2.
  - JALR (1100111, funct3 must be 000): ADD, A=0, B=1. Next: WB, wb_sel=2, pc_sel=3. The ALU inputs are held through WB.
  - MISC-MEM (0001111): NOP; pc_we_o=1, pc_sel 0. Next: FETCH.
  - SYSTEM and any other opcode: illegal, decided in DECODE.
- MEM:
  - mem_req_o=1, mem_addr_sel_o=1, mem_we_o=1 for stores.
  - ALU controls are held; wait for mem_ready_i.
  - Store on ready: pc_we_o=1, pc_sel 0, go to FETCH.
  - Load on ready: go to WB. IR is unchanged; the datapath latches the data.
- WB (one cycle):
  - rf_we_o=1 with wb_sel as above (load → 1, otherwise 0 unless jump).
  - pc_we_o=1, pc_sel 0 unless jump.
  - Go to FETCH.
- TRAP:
  - illegal_o=1; all other enables 0.
  - Stays in TRAP until reset.
- rd=x0 still asserts rf_we_o; the regfile ignores the write.
- mem_ready_i outside FETCH/MEM is ignored. A stalled FETCH/MEM holds all outputs stable.

Test Plan:
- Reset mid-FETCH with mem_req_o=1 → mem_req_o=0 immediately; after release, FETCH with IR=0x00000013 and alu_op_o=00000.
- Fetch 0x40B50533 (sub a0,a0,a1), mem_ready_i=1 → DECODE, then EXEC with alu_op_o=01000, then WB with rf_we_o=1, wb_sel_o=0, pc_we_o=1, pc_sel_o=0; 4 cycles total.
- Fetch 0x00B50463 (beq), alu_flag_i=1 in EXEC → alu_op_o=11000, pc_we_o=1, pc_sel_o=1, rf_we_o=0. Repeat with flag=0 → pc_sel_o=0.
- Fetch 0x00452283 (lw) with mem_ready_i low for 3 MEM cycles → mem_req_o=1, mem_addr_sel_o=1, mem_we_o=0 held stable; on ready → WB with rf_we_o=1, wb_sel_o=1.
- Fetch 0x000000E7 (jalr ra,0(x0)) → EXEC alu_op=ADD, B=1; WB with wb_sel_o=2, pc_sel_o=3.
- Fetch 0x00000073 (ecall) or 0x02B50533 (mul) → DECODE then TRAP with illegal_o=1 held for 10+ cycles; no rf/pc/mem enables; cleared only by arstn_i=0.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: control/status bundle between the multi-cycle controller and the datapath
interface multicycle_ctrl_if #(parameter int ALU_OP_W = 5);
  logic [31:0]         mem_rdata_i;
  logic                mem_ready_i;
  logic                alu_flag_i;
  logic [31:0]         instr_o;
  logic [ALU_OP_W-1:0] alu_op_o;
  logic [1:0]          src_a_sel_o;
  logic [2:0]          src_b_sel_o;
  logic                mem_req_o;
  logic                mem_we_o;
  logic                mem_addr_sel_o;
  logic                rf_we_o;
  logic [1:0]          wb_sel_o;
  logic                pc_we_o;
  logic [1:0]          pc_sel_o;
  logic                illegal_o;
  modport master (
    input  mem_rdata_i, mem_ready_i, alu_flag_i,
    output instr_o, alu_op_o, src_a_sel_o, src_b_sel_o, mem_req_o, mem_we_o,
           mem_addr_sel_o, rf_we_o, wb_sel_o, pc_we_o, pc_sel_o, illegal_o
  );
  modport slave (
    output mem_rdata_i, mem_ready_i, alu_flag_i,
    input  instr_o, alu_op_o, src_a_sel_o, src_b_sel_o, mem_req_o, mem_we_o,
           mem_addr_sel_o, rf_we_o, wb_sel_o, pc_we_o, pc_sel_o, illegal_o
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RISC-V multi-cycle control unit holding IR and sequencing FETCH/DECODE/EXEC/MEM/WB
module multicycle_ctrl #(
  parameter int          ALU_OP_W = 5,
  parameter logic [31:0] RESET_IR = 32'h00000013
) (
  input  logic               clk_i,
  input  logic               arstn_i,
  multicycle_ctrl_if.master  bus
);
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;

  state_t      r_state, w_next;
  logic [31:0] r_ir;
  logic [6:0]  w_opc, w_f7;
  logic [2:0]  w_f3;
  logic        w_illegal, w_alu_en;
  logic        w_is_load, w_is_store, w_is_branch, w_is_misc, w_is_jal, w_is_jalr;
  logic [4:0]  w_alu_op;
  logic [1:0]  w_a_sel;
  logic [2:0]  w_b_sel;

  assign w_opc       = r_ir[6:0];
  assign w_f3        = r_ir[14:12];
  assign w_f7        = r_ir[31:25];
  assign w_is_load   = w_opc == OPC_LOAD;
  assign w_is_store  = w_opc == OPC_STORE;
  assign w_is_branch = w_opc == OPC_BRANCH;
  assign w_is_misc   = w_opc == OPC_MISC;
  assign w_is_jal    = w_opc == OPC_JAL;
  assign w_is_jalr   = w_opc == OPC_JALR;

  always_comb begin
    w_illegal = 1'b1;
    case (w_opc)
      OPC_OP:     w_illegal = !(w_f7 == 7'h00 || (w_f7 == 7'h20 && (w_f3 == 3'b000 || w_f3 == 3'b101)));
      OPC_IMM:    w_illegal = (w_f3 == 3'b001 && w_f7 != 7'h00) ||
                              (w_f3 == 3'b101 && w_f7 != 7'h00 && w_f7 != 7'h20);
      OPC_BRANCH: w_illegal = w_f3[2:1] == 2'b01;
      OPC_JALR:   w_illegal = w_f3 != 3'b000;
      OPC_LOAD, OPC_STORE, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_MISC: w_illegal = 1'b0;
      default:    w_illegal = 1'b1;
    endcase
  end

  // funct7[5] selects SUB/SRA; OP-IMM has no SUBI so only the shift honours it
  always_comb begin
    w_alu_op = 5'b00000;
    w_a_sel  = 2'd0;
    w_b_sel  = 3'd0;
    case (w_opc)
      OPC_OP:     w_alu_op = {1'b0, w_f7[5] & (w_f3 == 3'b000 || w_f3 == 3'b101), w_f3};
      OPC_IMM:    begin w_alu_op = {1'b0, w_f7[5] & (w_f3 == 3'b101), w_f3}; w_b_sel = 3'd1; end
      OPC_LOAD:   w_b_sel = 3'd1;
      OPC_STORE:  w_b_sel = 3'd2;
      OPC_BRANCH: w_alu_op = {2'b11, w_f3};
      OPC_LUI:    begin w_a_sel = 2'd2; w_b_sel = 3'd3; end
      OPC_AUIPC:  begin w_a_sel = 2'd1; w_b_sel = 3'd3; end
      OPC_JALR:   w_b_sel = 3'd1;
      default:    w_alu_op = 5'b00000;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  w_next = bus.mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE: w_next = w_illegal ? S_TRAP : S_EXEC;
      S_EXEC:   w_next = (w_is_branch || w_is_misc) ? S_FETCH : (w_is_load || w_is_store) ? S_MEM : S_WB;
      S_MEM:    w_next = !bus.mem_ready_i ? S_MEM : w_is_store ? S_FETCH : S_WB;
      S_WB:     w_next = S_FETCH;
      default:  w_next = S_TRAP;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_state <= S_FETCH;
      r_ir    <= RESET_IR;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH && bus.mem_ready_i) r_ir <= bus.mem_rdata_i;
    end
  end

  // ALU controls stay valid from EXEC through MEM/WB so the datapath result is held
  assign w_alu_en           = r_state inside {S_EXEC, S_MEM, S_WB};
  assign bus.instr_o        = r_ir;
  assign bus.alu_op_o       = w_alu_en ? ALU_OP_W'(w_alu_op) : '0;
  assign bus.src_a_sel_o    = w_alu_en ? w_a_sel : 2'd0;
  assign bus.src_b_sel_o    = w_alu_en ? w_b_sel : 3'd0;
  assign bus.mem_req_o      = arstn_i && (r_state == S_FETCH || r_state == S_MEM);
  assign bus.mem_we_o       = r_state == S_MEM && w_is_store;
  assign bus.mem_addr_sel_o = r_state == S_MEM;
  assign bus.rf_we_o        = r_state == S_WB;
  assign bus.wb_sel_o       = r_state != S_WB ? 2'd0 : w_is_load ? 2'd1 : (w_is_jal || w_is_jalr) ? 2'd2 : 2'd0;
  assign bus.pc_we_o        = r_state == S_WB || (r_state == S_EXEC && (w_is_branch || w_is_misc)) ||
                              (r_state == S_MEM && w_is_store && bus.mem_ready_i);
  assign bus.pc_sel_o       = r_state == S_WB ? (w_is_jal ? 2'd2 : w_is_jalr ? 2'd3 : 2'd0) :
                              (r_state == S_EXEC && w_is_branch) ? {1'b0, bus.alu_flag_i} : 2'd0;
  assign bus.illegal_o      = r_state == S_TRAP;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed instruction sequences checked cycle by cycle against a scoreboard
module tb_multicycle_ctrl;
  localparam logic [31:0] NOP   = 32'h00000013;
  localparam logic [31:0] SUB   = 32'h40B50533;
  localparam logic [31:0] BEQ   = 32'h00B50463;
  localparam logic [31:0] LW    = 32'h00452283;
  localparam logic [31:0] SW    = 32'h00B52223;
  localparam logic [31:0] JALR  = 32'h000000E7;
  localparam logic [31:0] SRAI  = 32'h40355513;
  localparam logic [31:0] ECALL = 32'h00000073;
  localparam logic [31:0] MUL   = 32'h02B50533;

  logic clk = 1'b0;
  logic arstn = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [51:0] sb[$];
  string tq[$];
  logic [51:0] obs;

  multicycle_ctrl_if #(.ALU_OP_W(5)) bus ();
  multicycle_ctrl dut (.clk_i(clk), .arstn_i(arstn), .bus(bus));

  always #5 clk = ~clk;

  assign obs = {bus.instr_o, bus.alu_op_o, bus.src_a_sel_o, bus.src_b_sel_o, bus.mem_req_o, bus.mem_we_o,
                bus.mem_addr_sel_o, bus.rf_we_o, bus.wb_sel_o, bus.pc_we_o, bus.pc_sel_o, bus.illegal_o};

  function automatic logic [51:0] mk(input logic [31:0] ir, input logic [4:0] op, input logic [1:0] a,
                                     input logic [2:0] b, input logic rq, input logic we, input logic as,
                                     input logic rf, input logic [1:0] wb, input logic pw,
                                     input logic [1:0] ps, input logic il);
    return {ir, op, a, b, rq, we, as, rf, wb, pw, ps, il};
  endfunction

  function automatic logic [51:0] fe(input logic [31:0] ir);
    return mk(ir, 5'd0, 2'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
  endfunction

  function automatic logic [51:0] de(input logic [31:0] ir);
    return mk(ir, 5'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
  endfunction

  task automatic cyc(input logic n, input logic rdy, input logic [31:0] rd, input logic flg,
                     input string tag, input logic [51:0] e);
    logic [51:0] x;
    string t;
    @(negedge clk);
    arstn = n;
    bus.mem_ready_i = rdy;
    bus.mem_rdata_i = rd;
    bus.alu_flag_i = flg;
    sb.push_back(e);
    tq.push_back(tag);
    #1;
    x = sb.pop_front();
    t = tq.pop_front();
    checks++;
    assert (obs === x) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", t, obs, x);
    end
  endtask

  initial begin
    bus.mem_ready_i = 1'b0;
    bus.mem_rdata_i = 32'h0;
    bus.alu_flag_i = 1'b0;
    cyc(0, 0, 0, 0, "reset", de(NOP));
    cyc(1, 0, 0, 0, "fetch_wait", fe(NOP));
    cyc(0, 0, 0, 0, "reset_mid_fetch", de(NOP));
    cyc(1, 0, 0, 0, "fetch_after_reset", fe(NOP));
    cyc(1, 1, SUB, 0, "sub_fetch", fe(NOP));
    cyc(1, 0, 0, 0, "sub_decode", de(SUB));
    cyc(1, 0, 0, 0, "sub_exec", mk(SUB, 5'b01000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(1, 0, 0, 0, "sub_wb", mk(SUB, 5'b01000, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
    cyc(1, 1, BEQ, 0, "beq_fetch", fe(SUB));
    cyc(1, 0, 0, 0, "beq_decode", de(BEQ));
    cyc(1, 0, 0, 1, "beq_exec_taken", mk(BEQ, 5'b11000, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    cyc(1, 1, BEQ, 0, "beq_refetch", fe(BEQ));
    cyc(1, 0, 0, 0, "beq_decode2", de(BEQ));
    cyc(1, 0, 0, 0, "beq_exec_not_taken", mk(BEQ, 5'b11000, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    cyc(1, 1, LW, 0, "lw_fetch", fe(BEQ));
    cyc(1, 0, 0, 0, "lw_decode", de(LW));
    cyc(1, 0, 0, 0, "lw_exec", mk(LW, 5'd0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      cyc(1, 0, 32'hDEADBEEF, 1, "lw_mem_stall", mk(LW, 5'd0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0));
    cyc(1, 1, 32'h12345678, 0, "lw_mem_ready", mk(LW, 5'd0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0));
    cyc(1, 0, 0, 0, "lw_wb", mk(LW, 5'd0, 0, 1, 0, 0, 0, 1, 1, 1, 0, 0));
    cyc(1, 1, SW, 0, "sw_fetch", fe(LW));
    cyc(1, 0, 0, 0, "sw_decode", de(SW));
    cyc(1, 0, 0, 0, "sw_exec", mk(SW, 5'd0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(1, 0, 0, 0, "sw_mem_stall", mk(SW, 5'd0, 0, 2, 1, 1, 1, 0, 0, 0, 0, 0));
    cyc(1, 1, 0, 0, "sw_mem_ready", mk(SW, 5'd0, 0, 2, 1, 1, 1, 0, 0, 1, 0, 0));
    cyc(1, 1, JALR, 0, "jalr_fetch", fe(SW));
    cyc(1, 0, 0, 0, "jalr_decode", de(JALR));
    cyc(1, 0, 0, 0, "jalr_exec", mk(JALR, 5'd0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(1, 0, 0, 0, "jalr_wb", mk(JALR, 5'd0, 0, 1, 0, 0, 0, 1, 2, 1, 3, 0));
    cyc(1, 1, SRAI, 0, "srai_fetch", fe(JALR));
    cyc(1, 0, 0, 0, "srai_decode", de(SRAI));
    cyc(1, 0, 0, 0, "srai_exec", mk(SRAI, 5'b01101, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(1, 0, 0, 0, "srai_wb", mk(SRAI, 5'b01101, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0));
    cyc(1, 1, ECALL, 0, "ecall_fetch", fe(SRAI));
    cyc(1, 0, 0, 0, "ecall_decode", de(ECALL));
    for (int i = 0; i < 12; i++)
      cyc(1, 1'(i), $urandom, 1'($urandom), "ecall_trap", mk(ECALL, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    cyc(0, 0, 0, 0, "trap_reset", de(NOP));
    cyc(1, 1, MUL, 0, "mul_fetch", fe(NOP));
    cyc(1, 0, 0, 0, "mul_decode", de(MUL));
    for (int i = 0; i < 3; i++)
      cyc(1, 1, SUB, 0, "mul_trap", mk(MUL, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
